// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional hazard/flush statistics counters under IDEX_HAZ_STATS_EN.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int STALL_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [17:0]     id_cbus,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            flush,
  input  logic            stall_in,
  output logic            ex_valid,
  output logic [17:0]     ex_cbus,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            hz_stall
`ifdef IDEX_HAZ_STATS_EN
  ,
  output logic [31:0]     stat_stalls,
  output logic [31:0]     stat_flushes
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]      r_state;
  logic [1:0]      r_cnt;
  logic            r_valid;
  logic [17:0]     r_cbus;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;

  logic w_load;
  logic w_haz;
  logic w_hz;
  logic w_bubble;
  logic w_clr;

  assign w_load = r_valid & (r_cbus[8:7] == 2'b01);
  assign w_haz  = w_load & (r_rd != 5'd0) & id_valid
                & ((r_rd == id_rs1) | (r_rd == id_rs2));

  always_comb begin
    w_hz = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  w_hz = w_haz & ~flush & ~stall_in;
        default: w_hz = ~flush;
      endcase
    end
  end

  // flush outranks stall_in; stall_in outranks bubble insertion
  assign w_bubble = (r_state == S_STALL) | w_haz;
  assign w_clr    = rst | flush | (~stall_in & w_bubble);
  assign hz_stall = w_hz;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_valid    <= 1'b0;
      r_cbus     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
    end else if (!stall_in) begin
      r_valid    <= id_valid;
      r_cbus     <= id_cbus;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rd       <= id_rd;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else if (!stall_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_haz && (STALL_CYC > 1)) begin
            r_state <= S_STALL;
            r_cnt   <= 2'(STALL_CYC - 1);
          end
        end
        default: begin
          if (r_cnt <= 2'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
      endcase
    end
  end

  assign ex_valid    = r_valid;
  assign ex_cbus     = r_cbus;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rd       = r_rd;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;

`ifdef IDEX_HAZ_STATS_EN
  logic [31:0] r_stat_stalls;
  logic [31:0] r_stat_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_hz && (r_stat_stalls != 32'hFFFF_FFFF))
        r_stat_stalls <= r_stat_stalls + 32'd1;
      if (flush && id_valid && (r_stat_flushes != 32'hFFFF_FFFF))
        r_stat_flushes <= r_stat_flushes + 32'd1;
    end
  end

  assign stat_stalls  = r_stat_stalls;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instances at STALL_CYC=1 and 3
// (plus STALL_CYC=2 with statistics when IDEX_HAZ_STATS_EN is defined).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [17:0] id_cbus;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        flush, stall_in;

  logic        a_valid, b_valid;
  logic [17:0] a_cbus, b_cbus;
  logic [31:0] a_pc, a_d1, a_d2, a_imm;
  logic [31:0] b_pc, b_d1, b_d2, b_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic        a_hz, b_hz;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef IDEX_HAZ_STATS_EN
  logic [31:0] a_ss, a_sf, b_ss, b_sf, c_ss, c_sf;
  logic        c_valid, c_hz;
  logic [17:0] c_cbus;
  logic [31:0] c_pc, c_d1, c_d2, c_imm;
  logic [4:0]  c_rd, c_rs1, c_rs2;
`endif

  id_ex_stage #(.XLEN(32), .STALL_CYC(1)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cbus(id_cbus),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush(flush), .stall_in(stall_in),
    .ex_valid(a_valid), .ex_cbus(a_cbus), .ex_pc(a_pc),
    .ex_rs1_data(a_d1), .ex_rs2_data(a_d2), .ex_imm(a_imm),
    .ex_rd(a_rd), .ex_rs1(a_rs1), .ex_rs2(a_rs2), .hz_stall(a_hz)
`ifdef IDEX_HAZ_STATS_EN
    , .stat_stalls(a_ss), .stat_flushes(a_sf)
`endif
  );

  id_ex_stage #(.XLEN(32), .STALL_CYC(3)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cbus(id_cbus),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush(flush), .stall_in(stall_in),
    .ex_valid(b_valid), .ex_cbus(b_cbus), .ex_pc(b_pc),
    .ex_rs1_data(b_d1), .ex_rs2_data(b_d2), .ex_imm(b_imm),
    .ex_rd(b_rd), .ex_rs1(b_rs1), .ex_rs2(b_rs2), .hz_stall(b_hz)
`ifdef IDEX_HAZ_STATS_EN
    , .stat_stalls(b_ss), .stat_flushes(b_sf)
`endif
  );

`ifdef IDEX_HAZ_STATS_EN
  id_ex_stage #(.XLEN(32), .STALL_CYC(2)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cbus(id_cbus),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush(flush), .stall_in(stall_in),
    .ex_valid(c_valid), .ex_cbus(c_cbus), .ex_pc(c_pc),
    .ex_rs1_data(c_d1), .ex_rs2_data(c_d2), .ex_imm(c_imm),
    .ex_rd(c_rd), .ex_rs1(c_rs1), .ex_rs2(c_rs2), .hz_stall(c_hz),
    .stat_stalls(c_ss), .stat_flushes(c_sf)
  );
`endif

  localparam logic [17:0] LOAD = 18'h00080;
  localparam logic [17:0] ALU  = 18'h00020;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [17:0] cb,
                        input logic [31:0] pc, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2);
    id_valid    = v;
    id_cbus     = cb;
    id_pc       = pc;
    id_rs1_data = {16'hA000, pc[15:0]};
    id_rs2_data = {16'hB000, pc[15:0]};
    id_imm      = {16'hC000, pc[15:0]};
    id_rd       = rd;
    id_rs1      = s1;
    id_rs2      = s2;
  endtask

  task automatic do_reset();
    flush = 0;
    stall_in = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    flush = 0;
    stall_in = 0;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, 18'($urandom), $urandom, 5'($urandom),
             5'($urandom), 5'($urandom));
      step();
    end
    n_chk++;
    if (a_valid !== 1'b0) begin
      $display("FAIL reset_valid got %b want 0", a_valid); n_fail++;
    end
    n_chk++;
    if (a_cbus !== 18'h0 || b_cbus !== 18'h0) begin
      $display("FAIL reset_cbus got %h/%h want 0", a_cbus, b_cbus); n_fail++;
    end
    n_chk++;
    if (a_hz !== 1'b0 || b_hz !== 1'b0) begin
      $display("FAIL reset_hz got %b/%b want 0", a_hz, b_hz); n_fail++;
    end
    rst = 0;
    set_id(1'b1, ALU, 32'h100, 5'd1, 5'd2, 5'd3);
    step();
    n_chk++;
    if (a_pc !== 32'h100 || a_valid !== 1'b1) begin
      $display("FAIL first_capture got pc=%h v=%b want 100/1", a_pc, a_valid);
      n_fail++;
    end
  endtask

  task automatic test_load_use_1();
    do_reset();
    set_id(1'b1, LOAD, 32'h200, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h204, 5'd8, 5'd6, 5'd5);
    #1;
    n_chk++;
    if (a_hz !== 1'b1) begin
      $display("FAIL lu1_detect got %b want 1", a_hz); n_fail++;
    end
    step();
    n_chk++;
    if (a_valid !== 1'b0 || a_cbus !== 18'h0) begin
      $display("FAIL lu1_bubble got v=%b cb=%h want 0/0", a_valid, a_cbus);
      n_fail++;
    end
    n_chk++;
    if (a_hz !== 1'b0) begin
      $display("FAIL lu1_release got %b want 0", a_hz); n_fail++;
    end
    step();
    n_chk++;
    if (a_pc !== 32'h204 || a_d2 !== 32'hB000_0204 || a_cbus !== ALU
        || a_valid !== 1'b1 || a_rs2 !== 5'd5) begin
      $display("FAIL lu1_dep got pc=%h d2=%h cb=%h v=%b want 204/b0000204/20/1",
               a_pc, a_d2, a_cbus, a_valid);
      n_fail++;
    end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    set_id(1'b1, LOAD, 32'h220, 5'd0, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h224, 5'd4, 5'd0, 5'd0);
    #1;
    n_chk++;
    if (a_hz !== 1'b0 || b_hz !== 1'b0) begin
      $display("FAIL nofalse_rd0 got %b/%b want 0", a_hz, b_hz); n_fail++;
    end
    set_id(1'b1, LOAD, 32'h228, 5'd7, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h22C, 5'd4, 5'd3, 5'd4);
    #1;
    n_chk++;
    if (a_hz !== 1'b0 || b_hz !== 1'b0) begin
      $display("FAIL nofalse_rd7 got %b/%b want 0", a_hz, b_hz); n_fail++;
    end
  endtask

  task automatic test_load_use_3();
    do_reset();
    set_id(1'b1, LOAD, 32'h240, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h244, 5'd9, 5'd5, 5'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (b_hz !== 1'b1) begin
        $display("FAIL lu3_hz_cycle%0d got %b want 1", i, b_hz); n_fail++;
      end
      step();
      n_chk++;
      if (b_valid !== 1'b0 || b_cbus !== 18'h0) begin
        $display("FAIL lu3_bubble%0d got v=%b cb=%h want 0/0", i, b_valid, b_cbus);
        n_fail++;
      end
    end
    n_chk++;
    if (b_hz !== 1'b0) begin
      $display("FAIL lu3_release got %b want 0", b_hz); n_fail++;
    end
    step();
    n_chk++;
    if (b_pc !== 32'h244 || b_valid !== 1'b1 || b_d1 !== 32'hA000_0244) begin
      $display("FAIL lu3_dep got pc=%h v=%b want 244/1", b_pc, b_valid);
      n_fail++;
    end
  endtask

  task automatic test_flush_in_stall();
    do_reset();
    set_id(1'b1, LOAD, 32'h260, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h264, 5'd9, 5'd5, 5'd0);
    step();
    flush = 1;
    #1;
    n_chk++;
    if (b_hz !== 1'b0) begin
      $display("FAIL flush_stall_hz got %b want 0", b_hz); n_fail++;
    end
    step();
    flush = 0;
    n_chk++;
    if (b_valid !== 1'b0 || b_cbus !== 18'h0) begin
      $display("FAIL flush_stall_bubble got v=%b cb=%h want 0/0", b_valid, b_cbus);
      n_fail++;
    end
    set_id(1'b1, ALU, 32'h300, 5'd11, 5'd9, 5'd10);
    #1;
    n_chk++;
    if (b_hz !== 1'b0) begin
      $display("FAIL flush_stall_idle got %b want 0", b_hz); n_fail++;
    end
    step();
    n_chk++;
    if (b_pc !== 32'h300 || b_valid !== 1'b1) begin
      $display("FAIL flush_stall_next got pc=%h v=%b want 300/1", b_pc, b_valid);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, LOAD, 32'h280, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h284, 5'd9, 5'd5, 5'd0);
    flush = 1;
    stall_in = 1;
    #1;
    n_chk++;
    if (a_hz !== 1'b0 || b_hz !== 1'b0) begin
      $display("FAIL prio_hz got %b/%b want 0", a_hz, b_hz); n_fail++;
    end
    step();
    flush = 0;
    stall_in = 0;
    n_chk++;
    if (a_valid !== 1'b0 || a_cbus !== 18'h0 || b_valid !== 1'b0) begin
      $display("FAIL prio_bubble got v=%b cb=%h want 0/0", a_valid, a_cbus);
      n_fail++;
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    set_id(1'b1, 18'h12345, 32'h400, 5'd3, 5'd4, 5'd6);
    step();
    stall_in = 1;
    set_id(1'b1, LOAD, 32'h500, 5'd9, 5'd9, 5'd9);
    for (int i = 0; i < 4; i++) step();
    n_chk++;
    if (a_pc !== 32'h400 || a_cbus !== 18'h12345 || a_valid !== 1'b1) begin
      $display("FAIL hold_ctl got pc=%h cb=%h v=%b want 400/12345/1",
               a_pc, a_cbus, a_valid);
      n_fail++;
    end
    n_chk++;
    if (a_d1 !== 32'hA000_0400 || a_d2 !== 32'hB000_0400
        || a_imm !== 32'hC000_0400) begin
      $display("FAIL hold_data got %h %h %h want a0000400 b0000400 c0000400",
               a_d1, a_d2, a_imm);
      n_fail++;
    end
    n_chk++;
    if (a_rd !== 5'd3 || a_rs1 !== 5'd4 || a_rs2 !== 5'd6) begin
      $display("FAIL hold_idx got %0d %0d %0d want 3 4 6", a_rd, a_rs1, a_rs2);
      n_fail++;
    end
    stall_in = 0;
    set_id(1'b1, LOAD, 32'h510, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h514, 5'd9, 5'd5, 5'd0);
    stall_in = 1;
    #1;
    n_chk++;
    if (a_hz !== 1'b0) begin
      $display("FAIL stall_haz_hz got %b want 0", a_hz); n_fail++;
    end
    step();
    n_chk++;
    if (a_pc !== 32'h510 || a_cbus !== LOAD) begin
      $display("FAIL stall_haz_hold got pc=%h cb=%h want 510/80", a_pc, a_cbus);
      n_fail++;
    end
    stall_in = 0;
    #1;
    n_chk++;
    if (a_hz !== 1'b1) begin
      $display("FAIL stall_haz_reeval got %b want 1", a_hz); n_fail++;
    end
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    set_id(1'b1, LOAD, 32'h600, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h604, 5'd9, 5'd5, 5'd0);
    step();
    rst = 1;
    #1;
    n_chk++;
    if (b_hz !== 1'b0) begin
      $display("FAIL rst_stall_hz got %b want 0", b_hz); n_fail++;
    end
    step();
    rst = 0;
    #1;
    n_chk++;
    if (b_hz !== 1'b0 || b_valid !== 1'b0) begin
      $display("FAIL rst_stall_after got hz=%b v=%b want 0/0", b_hz, b_valid);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, ALU, 32'h700 + 32'(4 * i), 5'(i + 1), 5'd10, 5'd11);
      step();
      n_chk++;
      if (a_pc !== 32'h700 + 32'(4 * i) || a_rd !== 5'(i + 1)) begin
        $display("FAIL b2b_%0d got pc=%h rd=%0d want %h/%0d", i, a_pc, a_rd,
                 32'h700 + 32'(4 * i), i + 1);
        n_fail++;
      end
    end
  endtask

`ifdef IDEX_HAZ_STATS_EN
  task automatic test_stats();
    do_reset();
    set_id(1'b1, LOAD, 32'h800, 5'd5, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h804, 5'd9, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) step();
    set_id(1'b1, LOAD, 32'h808, 5'd6, 5'd1, 5'd2);
    step();
    set_id(1'b1, ALU, 32'h80C, 5'd9, 5'd0, 5'd6);
    for (int i = 0; i < 3; i++) step();
    flush = 1;
    set_id(1'b1, ALU, 32'h810, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) step();
    set_id(1'b0, ALU, 32'h814, 5'd1, 5'd2, 5'd3);
    step();
    flush = 0;
    n_chk++;
    if (c_ss !== 32'd4) begin
      $display("FAIL stat_stalls got %0d want 4", c_ss); n_fail++;
    end
    n_chk++;
    if (c_sf !== 32'd3) begin
      $display("FAIL stat_flushes got %0d want 3", c_sf); n_fail++;
    end
  endtask
`endif

  initial begin
    rst = 1;
    flush = 0;
    stall_in = 0;
    set_id(1'b0, 18'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_load_use_1();
    test_no_false_hazard();
    test_load_use_3();
    test_flush_in_stall();
    test_priority();
    test_stall_hold();
    test_rst_mid_stall();
    test_back_to_back();
`ifdef IDEX_HAZ_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
